load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64 only.
REQ-002 Parameter NBYTES, default XLEN/8, byte lanes per memory word; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  MEM-stage access request; pipeline holds request fields stable while busy=1.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RISC-V access type.
REQ-008 req_addr  input  XLEN  byte address.
REQ-009 req_wdata  input  XLEN  store data, least-significant bytes valid.
REQ-010 busy  output  1  stall request to hazard unit.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  XLEN  extended load result; 0 for stores and faults.
REQ-013 rsp_fault  output  1  misaligned or illegal access, valid with rsp_valid.
REQ-014 mem_valid / mem_write  output  1 / 1  memory request and direction.
REQ-015 mem_addr  output  XLEN  word-aligned address (low log2(NBYTES) bits zero).
REQ-016 mem_wdata / mem_be  output  XLEN / NBYTES  lane-replicated store data, byte enables.
REQ-017 mem_ready / mem_rdata  input  1 / XLEN  memory accepts/completes; read data valid when mem_ready=1.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; busy SHALL be 1 in ACCESS and RESP-entry cycle, i.e. whenever state!=IDLE.
REQ-019 IDLE & req_valid: latch request; legal aligned access -> ACCESS; otherwise -> RESP with fault latched, no memory access issued.
REQ-020 Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; XLEN=64 adds 011 ld, 110 lwu; all others fault.
REQ-021 Legal stores: 000 sb, 001 sh, 010 sw; XLEN=64 adds 011 sd; all others fault.
REQ-022 Misaligned: access size 2^k bytes faults when req_addr[k-1:0]!=0.
REQ-023 ACCESS: mem_valid=1, mem_addr/mem_wdata/mem_be/mem_write constant until mem_ready=1; transition to RESP on that edge, capturing mem_rdata.
REQ-024 mem_be = size mask (1,3,15,255) shifted left by req_addr[log2(NBYTES)-1:0]; mem_be=0 for loads.
REQ-025 mem_wdata = store byte/half/word/dword replicated across all lanes.
REQ-026 Load result: selected lane shifted to bit 0, sign-extended (signed types) or zero-extended (u types) to XLEN.
REQ-027 RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_valid in that cycle ignored (new request accepted earliest next cycle).
REQ-028 Latency: request accepted at edge N, mem_valid high from cycle N+1, mem_ready high at edge M -> rsp_valid in cycle M+1; fault -> rsp_valid in cycle N+1.
REQ-029 mem_ready outside ACCESS SHALL be ignored; req_valid during busy SHALL be ignored.
REQ-030 Unbounded wait: ACCESS held indefinitely while mem_ready=0.

Reset
REQ-031 reset high at an edge: state=IDLE; busy, rsp_valid, rsp_fault, mem_valid, mem_write=0; rsp_rdata, mem_addr, mem_wdata, mem_be=0.
REQ-032 Reset mid-ACCESS abandons the transaction: mem_valid low from the cycle after the reset edge, no rsp_valid generated.

Structure
REQ-033 Package lsu_pkg holds state enum, funct3 access-type constants, and size-to-mask function.
REQ-034 Combinational sub-module lsu_load_align performs lane select and extension (REQ-026); all state lives in load_store_unit.

Verification
REQ-035 XLEN=32, lw addr 0x104, mem_ready after 3 wait cycles, mem_rdata 0xDEADBEEF -> busy 5 cycles, rsp_rdata 0xDEADBEEF, rsp_fault 0.
REQ-036 XLEN=32, lb addr 0x103, mem_rdata 0x80112233 -> mem_be 0, rsp_rdata 0xFFFFFF80; lbu same -> 0x00000080.
REQ-037 XLEN=32, sh addr 0x22, wdata 0x0000ABCD -> mem_addr 0x20, mem_be 4'b1100, mem_wdata 0xABCDABCD.
REQ-038 XLEN=32, lw addr 0x102 -> no mem_valid, rsp_valid+rsp_fault next cycle, rsp_rdata 0; funct3 011 -> same fault.
REQ-039 XLEN=64, sd addr 0x8, wdata 0x0123456789ABCDEF -> mem_be 0xFF; lwu addr 0xC, mem_rdata 0x80000000_00000000 -> rsp_rdata 0x0000000080000000.
REQ-040 Reset asserted during ACCESS with mem_ready=0 -> next cycle mem_valid 0, busy 0, no rsp_valid; new request then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V
// access-type encodings, lane masks and access-legality decoding.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // funct3 access types (loads and stores share the low encodings)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-enable mask for an access of 2^size bytes, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // True when funct3 names an access type this XLEN supports.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3,
                                    input int unsigned xlen);
    logic ok;
    ok = 1'b0;
    if (write) begin
      case (funct3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        F3_D:             ok = (xlen == 64);
        default:          ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        F3_D, F3_WU:                    ok = (xlen == 64);
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed lane of a memory word down to bit 0 and extends it
// to XLEN according to the load type. Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned LANE_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] offset,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_B:    result = XLEN'($signed(shifted[7:0]));
      F3_H:    result = XLEN'($signed(shifted[15:0]));
      F3_W:    result = XLEN'($signed(shifted[31:0]));
      F3_BU:   result = XLEN'(shifted[7:0]);
      F3_HU:   result = XLEN'(shifted[15:0]);
      F3_WU:   result = XLEN'(shifted[31:0]);
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: decodes and checks one access, drives a
// single-outstanding memory request and returns an extended load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_fault,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_be,
  input  logic                  mem_ready,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(NBYTES);

  state_t            state;
  logic              lat_write;
  logic [2:0]        lat_funct3;
  logic [LANE_W-1:0] lat_offset;

  logic [1:0]        size_c;
  logic              misaligned_c;
  logic              legal_c;
  logic [NBYTES-1:0] be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   word_addr_c;
  logic [XLEN-1:0]   load_result_c;

  // Request decode: legality, alignment, lane enables and replicated data
  always_comb begin
    size_c       = req_funct3[1:0];
    misaligned_c = 1'b0;
    case (size_c)
      2'd0:    misaligned_c = 1'b0;
      2'd1:    misaligned_c = req_addr[0];
      2'd2:    misaligned_c = |req_addr[1:0];
      default: misaligned_c = |req_addr[2:0];
    endcase
    legal_c     = is_legal(req_write, req_funct3, XLEN) && !misaligned_c;
    be_c        = NBYTES'(size_mask(size_c)) << req_addr[LANE_W-1:0];
    word_addr_c = {req_addr[XLEN-1:LANE_W], LANE_W'(0)};
    case (size_c)
      2'd0:    wdata_c = {NBYTES{req_wdata[7:0]}};
      2'd1:    wdata_c = {(NBYTES / 2){req_wdata[15:0]}};
      2'd2:    wdata_c = {(XLEN / 32){req_wdata[31:0]}};
      default: wdata_c = req_wdata;
    endcase
  end

  // Aligns the raw memory word so the result is ready on the completing edge
  lsu_load_align #(
    .XLEN   (XLEN),
    .LANE_W (LANE_W)
  ) u_load_align (
    .funct3 (lat_funct3),
    .offset (lat_offset),
    .rdata  (mem_rdata),
    .result (load_result_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_write  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_offset <= '0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          if (req_valid) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_offset <= req_addr[LANE_W-1:0];
            busy       <= 1'b1;
            if (legal_c) begin
              state     <= ACCESS;
              mem_valid <= 1'b1;
              mem_write <= req_write;
              mem_addr  <= word_addr_c;
              mem_wdata <= req_write ? wdata_c : '0;
              mem_be    <= req_write ? be_c : '0;
            end else begin
              // Illegal or misaligned: answer directly, memory never sees it
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_be    <= '0;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= lat_write ? '0 : load_result_c;
          end
        end
        RESP: begin
          // req_valid in this cycle is deliberately not looked at
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          mem_valid <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
